// File: rtl/ls_loop_ctrl.sv
// ls_loop_ctrl: LQ/SQ loop-mode sequencer (capture, replay, drain, flush).
// Optional LOOP_ITER_LIMIT_EN forces an exit when iter_cnt reaches MAX_ITER.
module ls_loop_ctrl #(
    parameter int LQ_AW    = 5,
    parameter int SQ_AW    = 4,
    parameter int ITER_W   = 8,
    parameter int MAX_ITER = 200
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              loop_strt,
    input  logic              fnsh_unrll,
    input  logic [LQ_AW-1:0]  lq_tail,
    input  logic [SQ_AW-1:0]  sq_tail,
    input  logic              iter_done,
    input  logic              loop_exit,
    input  logic              body_drained,
    input  logic              flsh,
    input  logic [LQ_AW-1:0]  mis_pred_ld_ptr,
    output logic              loop_mode,
    output logic [LQ_AW-1:0]  lq_loop_start,
    output logic [LQ_AW-1:0]  lq_loop_end,
    output logic [SQ_AW-1:0]  sq_loop_start,
    output logic [SQ_AW-1:0]  sq_loop_end,
    output logic              replay,
    output logic              flush_body,
    output logic              stll,
    output logic [ITER_W-1:0] iter_cnt,
    output logic              lim_hit
);
    typedef enum logic [2:0] {IDLE, CAPT, LOOP, DRAIN, ABORT} state_t;
    state_t state, nxt;
    logic rep_d, lim_d, inc_d, in_body, empty;
    logic [ITER_W-1:0] cnt_nxt;
    // Body window may wrap past the top of the LQ.
    assign in_body = (lq_loop_start <= lq_loop_end)
        ? (mis_pred_ld_ptr >= lq_loop_start && mis_pred_ld_ptr <= lq_loop_end)
        : (mis_pred_ld_ptr >= lq_loop_start || mis_pred_ld_ptr <= lq_loop_end);
    assign empty   = lq_tail == lq_loop_start && sq_tail == sq_loop_start;
    assign cnt_nxt = &iter_cnt ? iter_cnt : iter_cnt + 1'b1;
`ifndef LOOP_ITER_LIMIT_EN
    logic unused_max;
    assign unused_max = MAX_ITER > 0;
`endif
    always_comb begin
        nxt   = state;
        rep_d = 1'b0;
        lim_d = 1'b0;
        inc_d = 1'b0;
        case (state)
            IDLE: if (loop_strt) nxt = CAPT;
            CAPT: begin
                if (flsh) nxt = IDLE;
                else if (fnsh_unrll) nxt = empty ? IDLE : LOOP;
            end
            LOOP: begin
                if (flsh && in_body) nxt = ABORT;
                else begin
                    inc_d = iter_done;
                    if (loop_exit) nxt = DRAIN;
                    else if (iter_done) begin
`ifdef LOOP_ITER_LIMIT_EN
                        if (cnt_nxt == ITER_W'(MAX_ITER)) begin
                            nxt   = DRAIN;
                            lim_d = 1'b1;
                        end else rep_d = 1'b1;
`else
                        rep_d = 1'b1;
`endif
                    end
                end
            end
            DRAIN: begin
                if (flsh && in_body) nxt = ABORT;
                else if (body_drained) nxt = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            loop_mode     <= 1'b0;
            stll          <= 1'b0;
            replay        <= 1'b0;
            flush_body    <= 1'b0;
            lim_hit       <= 1'b0;
            iter_cnt      <= '0;
            lq_loop_start <= '0;
            lq_loop_end   <= '0;
            sq_loop_start <= '0;
            sq_loop_end   <= '0;
        end else begin
            state      <= nxt;
            loop_mode  <= nxt == LOOP || nxt == DRAIN;
            stll       <= nxt == LOOP;
            replay     <= rep_d;
            flush_body <= nxt == ABORT;
            lim_hit    <= lim_d;
            if (inc_d) iter_cnt <= cnt_nxt;
            if (state == IDLE && loop_strt) begin
                lq_loop_start <= lq_tail;
                sq_loop_start <= sq_tail;
                iter_cnt      <= '0;
            end
            if (state == CAPT && nxt == LOOP) begin
                lq_loop_end <= lq_tail - LQ_AW'(1);
                sq_loop_end <= sq_tail - SQ_AW'(1);
            end
            if (nxt == IDLE) begin
                lq_loop_start <= '0;
                lq_loop_end   <= '0;
                sq_loop_start <= '0;
                sq_loop_end   <= '0;
            end
        end
    end
endmodule

// File: tb/tb_ls_loop_ctrl.sv
// tb_ls_loop_ctrl: vector table, corner sequences and random run against a reference model.
module tb_ls_loop_ctrl;
    localparam int LQ_AW = 5, SQ_AW = 4, ITER_W = 8;
`ifdef LOOP_ITER_LIMIT_EN
    localparam int MAX_ITER = 4;
`else
    localparam int MAX_ITER = 200;
`endif
    logic clk = 0, rst = 0;
    logic loop_strt = 0, fnsh_unrll = 0, iter_done = 0, loop_exit = 0, body_drained = 0, flsh = 0;
    logic [LQ_AW-1:0] lq_tail = 0, mis_pred_ld_ptr = 0, lq_loop_start, lq_loop_end;
    logic [SQ_AW-1:0] sq_tail = 0, sq_loop_start, sq_loop_end;
    logic loop_mode, replay, flush_body, stll, lim_hit;
    logic [ITER_W-1:0] iter_cnt;
    int checks = 0, failures = 0;

    ls_loop_ctrl #(.LQ_AW(LQ_AW), .SQ_AW(SQ_AW), .ITER_W(ITER_W), .MAX_ITER(MAX_ITER)) dut (
        .clk(clk), .rst(rst), .loop_strt(loop_strt), .fnsh_unrll(fnsh_unrll),
        .lq_tail(lq_tail), .sq_tail(sq_tail), .iter_done(iter_done), .loop_exit(loop_exit),
        .body_drained(body_drained), .flsh(flsh), .mis_pred_ld_ptr(mis_pred_ld_ptr),
        .loop_mode(loop_mode), .lq_loop_start(lq_loop_start), .lq_loop_end(lq_loop_end),
        .sq_loop_start(sq_loop_start), .sq_loop_end(sq_loop_end), .replay(replay),
        .flush_body(flush_body), .stll(stll), .iter_cnt(iter_cnt), .lim_hit(lim_hit));

    always #5 clk = ~clk;

    typedef struct {
        logic strt, fnsh, idone, ext, drn, fl;
        int lqt, sqt, ptr;
        logic mode, stl, rep, fb;
        int cnt, lqs, lqe, sqs, sqe;
    } vec_t;
    vec_t vecs[$];

    // Reference model: phase name plus pointer window, advanced once per clock edge.
    string ph;
    int m_cnt, m_lqs, m_lqe, m_sqs, m_sqe;
    bit m_rep, m_fb, m_lim;

    function automatic bit inside_body(int p, int s, int e);
        return ((p - s + 32) % 32) <= ((e - s + 32) % 32);
    endfunction

    task automatic model_reset();
        ph = "IDLE";
        m_cnt = 0; m_lqs = 0; m_lqe = 0; m_sqs = 0; m_sqe = 0;
        m_rep = 0; m_fb = 0; m_lim = 0;
    endtask

    task automatic go_idle();
        ph = "IDLE";
        m_lqs = 0; m_lqe = 0; m_sqs = 0; m_sqe = 0;
    endtask

    task automatic model_step();
        bit hit;
        m_rep = 0; m_fb = 0; m_lim = 0;
        hit = flsh && inside_body(int'(mis_pred_ld_ptr), m_lqs, m_lqe);
        if (ph == "IDLE") begin
            if (loop_strt) begin
                m_lqs = int'(lq_tail); m_sqs = int'(sq_tail); m_cnt = 0; ph = "CAPT";
            end
        end else if (ph == "CAPT") begin
            if (flsh) go_idle();
            else if (fnsh_unrll) begin
                if (int'(lq_tail) == m_lqs && int'(sq_tail) == m_sqs) go_idle();
                else begin
                    m_lqe = (int'(lq_tail) + 31) % 32;
                    m_sqe = (int'(sq_tail) + 15) % 16;
                    ph = "LOOP";
                end
            end
        end else if (ph == "LOOP") begin
            if (hit) begin ph = "ABORT"; m_fb = 1; end
            else begin
                if (iter_done && m_cnt < 255) m_cnt++;
                if (loop_exit) ph = "DRAIN";
                else if (iter_done) begin
`ifdef LOOP_ITER_LIMIT_EN
                    if (m_cnt == MAX_ITER) begin ph = "DRAIN"; m_lim = 1; end
                    else m_rep = 1;
`else
                    m_rep = 1;
`endif
                end
            end
        end else if (ph == "DRAIN") begin
            if (hit) begin ph = "ABORT"; m_fb = 1; end
            else if (body_drained) go_idle();
        end else go_idle();
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("m_loop_mode", loop_mode, ph == "LOOP" || ph == "DRAIN");
        chk("m_stll", stll, ph == "LOOP");
        chk("m_replay", replay, m_rep);
        chk("m_flush_body", flush_body, m_fb);
        chk("m_lim_hit", lim_hit, m_lim);
        chk("m_iter_cnt", iter_cnt, m_cnt);
        chk("m_lq_start", lq_loop_start, m_lqs);
        chk("m_lq_end", lq_loop_end, m_lqe);
        chk("m_sq_start", sq_loop_start, m_sqs);
        chk("m_sq_end", sq_loop_end, m_sqe);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic drive(input logic s, f, d, e, dr, fl, input int lqt, sqt, ptr);
        loop_strt = s; fnsh_unrll = f; iter_done = d; loop_exit = e; body_drained = dr; flsh = fl;
        lq_tail = LQ_AW'(lqt); sq_tail = SQ_AW'(sqt); mis_pred_ld_ptr = LQ_AW'(ptr);
    endtask

    initial begin
        //            s f d e dr fl lqt sqt ptr  mode stl rep fb cnt lqs lqe sqs sqe
        vecs.push_back('{1,0,0,0,0,0, 2, 1, 0,  0,0,0,0, 0, 2, 0, 1, 0});
        vecs.push_back('{0,1,0,0,0,0, 6, 3, 0,  1,1,0,0, 0, 2, 5, 1, 2});
        vecs.push_back('{0,0,1,0,0,0, 6, 3, 0,  1,1,1,0, 1, 2, 5, 1, 2});
        vecs.push_back('{0,0,0,0,0,0, 6, 3, 0,  1,1,0,0, 1, 2, 5, 1, 2});
        vecs.push_back('{0,0,1,0,0,0, 6, 3, 0,  1,1,1,0, 2, 2, 5, 1, 2});
        vecs.push_back('{0,0,1,0,0,0, 6, 3, 0,  1,1,1,0, 3, 2, 5, 1, 2});
        vecs.push_back('{0,0,0,0,0,1, 6, 3, 9,  1,1,0,0, 3, 2, 5, 1, 2});
        vecs.push_back('{0,0,0,1,0,0, 6, 3, 0,  1,0,0,0, 3, 2, 5, 1, 2});
        vecs.push_back('{0,0,0,0,0,0, 6, 3, 0,  1,0,0,0, 3, 2, 5, 1, 2});
        vecs.push_back('{0,0,0,0,1,0, 6, 3, 0,  0,0,0,0, 3, 0, 0, 0, 0});
        vecs.push_back('{1,0,0,0,0,0,30,14, 0,  0,0,0,0, 0,30, 0,14, 0});
        vecs.push_back('{1,0,0,0,0,0,31,15, 0,  0,0,0,0, 0,30, 0,14, 0});
        vecs.push_back('{0,1,0,0,0,0, 2, 1, 0,  1,1,0,0, 0,30, 1,14, 0});
        vecs.push_back('{0,0,0,0,0,1, 2, 1, 0,  0,0,0,1, 0,30, 1,14, 0});
        vecs.push_back('{0,0,0,0,0,0, 2, 1, 0,  0,0,0,0, 0, 0, 0, 0, 0});
        vecs.push_back('{1,0,0,0,0,0, 7, 3, 0,  0,0,0,0, 0, 7, 0, 3, 0});
        vecs.push_back('{0,1,0,0,0,0, 7, 3, 0,  0,0,0,0, 0, 0, 0, 0, 0});
        vecs.push_back('{1,0,0,0,0,0, 4, 4, 0,  0,0,0,0, 0, 4, 0, 4, 0});
        vecs.push_back('{0,1,0,0,0,0, 8, 5, 0,  1,1,0,0, 0, 4, 7, 4, 4});
        vecs.push_back('{0,0,1,1,0,0, 8, 5, 0,  1,0,0,0, 1, 4, 7, 4, 4});
        vecs.push_back('{0,0,0,0,1,0, 8, 5, 0,  0,0,0,0, 1, 0, 0, 0, 0});
        vecs.push_back('{1,0,0,0,0,0,10, 2, 0,  0,0,0,0, 0,10, 0, 2, 0});
        vecs.push_back('{0,1,0,0,0,1,12, 3,10,  0,0,0,0, 0, 0, 0, 0, 0});
        vecs.push_back('{0,1,1,1,1,1,12, 3, 0,  0,0,0,0, 0, 0, 0, 0, 0});

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_model();
        @(negedge clk);
        rst = 1;

        foreach (vecs[i]) begin
            drive(vecs[i].strt, vecs[i].fnsh, vecs[i].idone, vecs[i].ext, vecs[i].drn, vecs[i].fl,
                  vecs[i].lqt, vecs[i].sqt, vecs[i].ptr);
            tick();
            chk($sformatf("v%0d_loop_mode", i), loop_mode, vecs[i].mode);
            chk($sformatf("v%0d_stll", i), stll, vecs[i].stl);
            chk($sformatf("v%0d_replay", i), replay, vecs[i].rep);
            chk($sformatf("v%0d_flush_body", i), flush_body, vecs[i].fb);
            chk($sformatf("v%0d_iter_cnt", i), iter_cnt, vecs[i].cnt);
            chk($sformatf("v%0d_lq_start", i), lq_loop_start, vecs[i].lqs);
            chk($sformatf("v%0d_lq_end", i), lq_loop_end, vecs[i].lqe);
            chk($sformatf("v%0d_sq_start", i), sq_loop_start, vecs[i].sqs);
            chk($sformatf("v%0d_sq_end", i), sq_loop_end, vecs[i].sqe);
            chk($sformatf("v%0d_lim_hit", i), lim_hit, 0);
        end

        // Asynchronous reset in the middle of a loop.
        drive(1,0,0,0,0,0, 3,2,0); tick();
        drive(0,1,0,0,0,0, 9,6,0); tick();
        drive(0,0,1,0,0,0, 9,6,0); tick();
        chk("pre_rst_mode", loop_mode, 1);
        #2 rst = 0;
        #1;
        chk("arst_mode", loop_mode, 0);
        chk("arst_stll", stll, 0);
        chk("arst_replay", replay, 0);
        chk("arst_flush_body", flush_body, 0);
        chk("arst_cnt", iter_cnt, 0);
        chk("arst_lq_start", lq_loop_start, 0);
        chk("arst_lq_end", lq_loop_end, 0);
        chk("arst_sq_start", sq_loop_start, 0);
        chk("arst_sq_end", sq_loop_end, 0);
        model_reset();
        drive(0,0,0,0,0,0, 0,0,0);
        @(negedge clk);
        rst = 1;
        tick();
        chk("post_rst_flush_body", flush_body, 0);

        drive(1,0,0,0,0,0, 0,0,0); tick();
        drive(0,1,0,0,0,0, 3,2,0); tick();
`ifdef LOOP_ITER_LIMIT_EN
        for (int k = 1; k < MAX_ITER; k++) begin
            drive(0,0,1,0,0,0, 3,2,0); tick();
            chk("lim_replay", replay, 1);
            chk("lim_no_hit", lim_hit, 0);
        end
        drive(0,0,1,0,0,0, 3,2,0); tick();
        chk("lim_hit", lim_hit, 1);
        chk("lim_no_replay", replay, 0);
        chk("lim_cnt", iter_cnt, MAX_ITER);
        chk("lim_drain_mode", loop_mode, 1);
        chk("lim_drain_stll", stll, 0);
        drive(0,0,0,0,0,0, 3,2,0); tick();
        chk("lim_pulse_end", lim_hit, 0);
`else
        drive(0,0,1,0,0,0, 3,2,0);
        repeat (260) tick();
        chk("sat_cnt", iter_cnt, 255);
        chk("sat_replay", replay, 1);
        chk("sat_lim_hit", lim_hit, 0);
        drive(0,0,0,1,0,0, 3,2,0); tick();
`endif
        drive(0,0,0,0,1,0, 3,2,0); tick();
        chk("seq_idle_mode", loop_mode, 0);

        for (int n = 0; n < 3000; n++) begin
            drive($urandom_range(0,9) < 3, $urandom_range(0,9) < 3, $urandom_range(0,9) < 3,
                  $urandom_range(0,19) == 0, $urandom_range(0,9) < 2, $urandom_range(0,19) == 0,
                  $urandom_range(0,31), $urandom_range(0,15), $urandom_range(0,31));
            if ($urandom_range(0,7) == 0) begin
                lq_tail = LQ_AW'(m_lqs);
                sq_tail = SQ_AW'(m_sqs);
            end
            tick();
            check_model();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
